real2cpx_mc: RTL and testbench



---
 rtl/real2cpx_mc.sv | 186 ++++++++++++++++++
 tb/tb_real2cpx_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/real2cpx_mc.sv
// Multi-channel real-to-complex converter: fs/4 quadrature mixer plus boxcar low-pass,
// one time-shared datapath. Optional dropped-sample counter under REAL2CPX_OVR_CNT_EN.
module real2cpx_mc #(
  parameter int unsigned W         = 12,
  parameter int unsigned NCH       = 2,
  parameter int unsigned LOG2_TAPS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           data_rdy,
  input  logic [NCH*W-1:0]               x_rx,
  output logic [NCH*(W+LOG2_TAPS)-1:0]   re,
  output logic [NCH*(W+LOG2_TAPS)-1:0]   im,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun
`ifdef REAL2CPX_OVR_CNT_EN
  ,
  output logic [7:0]                     ovr_cnt
`endif
);

  localparam int unsigned OW   = W + LOG2_TAPS;
  localparam int unsigned SW   = OW + 1;
  localparam int unsigned MW   = W + 1;
  localparam int unsigned TAPS = 1 << LOG2_TAPS;
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic [1:0]             phase_q, phase_d;
  logic [NCH*W-1:0]       samp_q, samp_d;
  logic signed [MW-1:0]   hist_re_q [NCH][TAPS];
  logic signed [MW-1:0]   hist_re_d [NCH][TAPS];
  logic signed [MW-1:0]   hist_im_q [NCH][TAPS];
  logic signed [MW-1:0]   hist_im_d [NCH][TAPS];
  logic signed [SW-1:0]   sum_re_q [NCH];
  logic signed [SW-1:0]   sum_re_d [NCH];
  logic signed [SW-1:0]   sum_im_q [NCH];
  logic signed [SW-1:0]   sum_im_d [NCH];
  logic [NCH*OW-1:0]      re_q, re_d;
  logic [NCH*OW-1:0]      im_q, im_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
`ifdef REAL2CPX_OVR_CNT_EN
  logic [7:0]             ovr_cnt_q, ovr_cnt_d;
`endif

  logic signed [W-1:0]    x_cur;
  logic signed [MW-1:0]   x_ext;
  logic signed [MW-1:0]   x_neg;
  logic signed [MW-1:0]   mix_re;
  logic signed [MW-1:0]   mix_im;

  // Next-state, datapath and output logic
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    phase_d     = phase_q;
    samp_d      = samp_q;
    hist_re_d   = hist_re_q;
    hist_im_d   = hist_im_q;
    sum_re_d    = sum_re_q;
    sum_im_d    = sum_im_q;
    re_d        = re_q;
    im_d        = im_q;
    out_valid_d = 1'b0;
    busy_d      = (state_q != S_IDLE);
    overrun_d   = overrun_q;
`ifdef REAL2CPX_OVR_CNT_EN
    ovr_cnt_d   = ovr_cnt_q;
`endif

    // Mixed value widened by one bit so negating the most negative sample is exact
    x_cur = signed'(samp_q[ch_q*W +: W]);
    x_ext = MW'(x_cur);
    x_neg = -x_ext;
    mix_re = '0;
    mix_im = '0;
    case (phase_q)
      2'd0:    mix_re = x_ext;
      2'd1:    mix_im = x_neg;
      2'd2:    mix_re = x_neg;
      default: mix_im = x_ext;
    endcase

    if (data_rdy && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
`ifdef REAL2CPX_OVR_CNT_EN
      if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (data_rdy) begin
          samp_d  = x_rx;
          ch_d    = '0;
          state_d = S_PROC;
        end
      end
      S_PROC: begin
        sum_re_d[ch_q] = sum_re_q[ch_q] + SW'(mix_re) - SW'(hist_re_q[ch_q][TAPS-1]);
        sum_im_d[ch_q] = sum_im_q[ch_q] + SW'(mix_im) - SW'(hist_im_q[ch_q][TAPS-1]);
        for (int t = TAPS - 1; t > 0; t--) begin
          hist_re_d[ch_q][t] = hist_re_q[ch_q][t-1];
          hist_im_d[ch_q][t] = hist_im_q[ch_q][t-1];
        end
        hist_re_d[ch_q][0] = mix_re;
        hist_im_d[ch_q][0] = mix_im;
        if (ch_q == CHW'(NCH - 1)) state_d = S_OUT;
        else                       ch_d    = ch_q + 1'b1;
      end
      S_OUT: begin
        out_valid_d = 1'b1;
        phase_d     = phase_q + 2'd1;
        for (int k = 0; k < NCH; k++) begin
          re_d[k*OW +: OW] = OW'(sum_re_q[k]);
          im_d[k*OW +: OW] = OW'(sum_im_q[k]);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      phase_q     <= '0;
      samp_q      <= '0;
      for (int k = 0; k < NCH; k++) begin
        sum_re_q[k] <= '0;
        sum_im_q[k] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          hist_re_q[k][t] <= '0;
          hist_im_q[k][t] <= '0;
        end
      end
      re_q        <= '0;
      im_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef REAL2CPX_OVR_CNT_EN
      ovr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      phase_q     <= phase_d;
      samp_q      <= samp_d;
      sum_re_q    <= sum_re_d;
      sum_im_q    <= sum_im_d;
      hist_re_q   <= hist_re_d;
      hist_im_q   <= hist_im_d;
      re_q        <= re_d;
      im_q        <= im_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef REAL2CPX_OVR_CNT_EN
      ovr_cnt_q   <= ovr_cnt_d;
`endif
    end
  end

  assign re        = re_q;
  assign im        = im_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
`ifdef REAL2CPX_OVR_CNT_EN
  assign ovr_cnt   = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_real2cpx_mc.sv
// Scoreboard bench for real2cpx_mc: window-sum reference model, randomized and directed stimulus.
module tb_real2cpx_mc;

  localparam int unsigned W         = 12;
  localparam int unsigned NCH       = 2;
  localparam int unsigned LOG2_TAPS = 1;
  localparam int unsigned OW        = W + LOG2_TAPS;
  localparam int unsigned TAPS      = 1 << LOG2_TAPS;

  logic                clk = 1'b0;
  logic                reset;
  logic                data_rdy;
  logic [NCH*W-1:0]    x_rx;
  logic [NCH*OW-1:0]   re;
  logic [NCH*OW-1:0]   im;
  logic                out_valid;
  logic                busy;
  logic                overrun;
`ifdef REAL2CPX_OVR_CNT_EN
  logic [7:0]          ovr_cnt;
`endif

  always #5 clk = ~clk;

  real2cpx_mc #(.W(W), .NCH(NCH), .LOG2_TAPS(LOG2_TAPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_rdy  (data_rdy),
    .x_rx      (x_rx),
    .re        (re),
    .im        (im),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
`ifdef REAL2CPX_OVR_CNT_EN
    ,
    .ovr_cnt   (ovr_cnt)
`endif
  );

  typedef struct {
    int re [NCH];
    int im [NCH];
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int   phase_m;
  int   hist_re_m [NCH][$];
  int   hist_im_m [NCH][$];
  bit   ovr_m;
  int   ovr_cnt_m;
  int   edge_n = 0;
  int   last_acc;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    phase_m = 0;
    for (int k = 0; k < NCH; k++) begin
      hist_re_m[k].delete();
      hist_im_m[k].delete();
    end
    exp_q.delete();
    ovr_m     = 1'b0;
    ovr_cnt_m = 0;
    last_acc  = -100;
  endtask

  // Output is the plain sum of the last TAPS mixed values (missing history counts as zero)
  task automatic model_accept(input int xs [NCH]);
    exp_t e;
    int mr, mi;
    for (int k = 0; k < NCH; k++) begin
      case (phase_m)
        0:       begin mr = xs[k];  mi = 0;      end
        1:       begin mr = 0;      mi = -xs[k]; end
        2:       begin mr = -xs[k]; mi = 0;      end
        default: begin mr = 0;      mi = xs[k];  end
      endcase
      hist_re_m[k].push_front(mr);
      hist_im_m[k].push_front(mi);
      if (hist_re_m[k].size() > TAPS) void'(hist_re_m[k].pop_back());
      if (hist_im_m[k].size() > TAPS) void'(hist_im_m[k].pop_back());
      e.re[k] = 0;
      e.im[k] = 0;
      foreach (hist_re_m[k][i]) e.re[k] += hist_re_m[k][i];
      foreach (hist_im_m[k][i]) e.im[k] += hist_im_m[k][i];
    end
    exp_q.push_back(e);
    phase_m = (phase_m + 1) % 4;
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Issue one data_rdy; the model decides acceptance from the minimum spacing rule
  task automatic send(input int xs [NCH], input int gap);
    for (int k = 0; k < NCH; k++) x_rx[k*W +: W] = W'(xs[k]);
    data_rdy = 1'b1;
    if (edge_n + 1 - last_acc >= int'(NCH) + 2) begin
      last_acc = edge_n + 1;
      model_accept(xs);
    end else begin
      ovr_m = 1'b1;
      if (ovr_cnt_m < 255) ovr_cnt_m++;
    end
    step();
    data_rdy = 1'b0;
    check("overrun", int'(overrun), int'(ovr_m));
`ifdef REAL2CPX_OVR_CNT_EN
    check("ovr_cnt", int'(ovr_cnt), ovr_cnt_m);
`endif
    for (int i = 1; i < gap; i++) step();
  endtask

  task automatic apply_reset(input int cycles, input bit toggle);
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (toggle) data_rdy = ~data_rdy;
      step();
      check("rst_re_nonzero", int'(|re), 0);
      check("rst_im_nonzero", int'(|im), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
    end
    model_reset();
    data_rdy = 1'b0;
    reset    = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < NCH; k++) begin
          check($sformatf("re_ch%0d", k), int'($signed(re[k*OW +: OW])), e.re[k]);
          check($sformatf("im_ch%0d", k), int'($signed(im[k*OW +: OW])), e.im[k]);
        end
      end
    end
  end

  initial begin
    int seq [4];
    int xs [NCH];
    int waited;
    seq[0] = 2047; seq[1] = 0; seq[2] = -2048; seq[3] = 0;
    reset    = 1'b0;
    data_rdy = 1'b0;
    x_rx     = '0;
    model_reset();

    apply_reset(3, 1'b1);
    step();

    // Constant input: ch0=100, ch1=-50
    for (int i = 0; i < 5; i++) send('{100, -50}, 20);

    // Latency and busy timing
    send('{7, -3}, 1);
    check("lat_busy_t0", int'(busy), 0);
    check("lat_ov_t0", int'(out_valid), 0);
    step();
    check("lat_busy_t1", int'(busy), 1);
    step();
    check("lat_ov_t2", int'(out_valid), 0);
    step();
    check("lat_ov_t3", int'(out_valid), 1);
    check("lat_busy_t3", int'(busy), 1);
    step();
    check("lat_ov_t4", int'(out_valid), 0);
    check("lat_busy_t4", int'(busy), 0);
    for (int i = 0; i < 10; i++) step();

    // Overrun: second strobe two cycles after the first is dropped
    send('{300, -300}, 2);
    send('{999, 999}, 10);
    check("overrun_sticky", int'(overrun), 1);
    send('{-11, 22}, 10);
    check("overrun_held", int'(overrun), 1);

    // Extremes through the boxcar, fresh history
    apply_reset(1, 1'b0);
    step();
    for (int i = 0; i < 12; i++) send('{seq[i % 4], -2048}, 6);
    send('{-2048, 2047}, 6);

    // Reset during PROC aborts the sample; next sample restarts from phase 0
    send('{500, 500}, 1);
    apply_reset(1, 1'b0);
    for (int i = 0; i < 8; i++) step();
    send('{100, -50}, 8);

    // Randomized spacing and values, including back-to-back strobes
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NCH; k++) xs[k] = int'($urandom_range(0, 4095)) - 2048;
      send(xs, int'($urandom_range(1, 8)));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      step();
      waited++;
    end
    check("drain_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
